gray_window_buffer: RTL and testbench

//   Sits directly downstream of the RGB-to-gray converter and consumes its gray pixels.

---
 rtl/gray_window_buffer_pkg.sv | 30 +++
 rtl/gray_window_buffer_if.sv | 35 +++
 rtl/gray_window_buffer_lb.sv | 22 ++
 rtl/gray_window_buffer.sv | 113 +++++++++++
 tb/tb_gray_window_buffer.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/gray_window_buffer_pkg.sv
// Shared constants for the gray 3x3 window buffer: window slot indices,
// default geometry and a width helper.
package gray_window_buffer_pkg;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_IMG_WIDTH  = 64;
    localparam int DEF_IMG_HEIGHT = 64;

    // Slot k = 3*r + c; r=0 is the oldest line, c=0 the oldest column.
    localparam int WIN_TL = 0;
    localparam int WIN_TC = 1;
    localparam int WIN_TR = 2;
    localparam int WIN_ML = 3;
    localparam int WIN_MC = 4;
    localparam int WIN_MR = 5;
    localparam int WIN_BL = 6;
    localparam int WIN_BC = 7;
    localparam int WIN_BR = 8;
    localparam int WIN_SLOTS = 9;

    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/gray_window_buffer_if.sv
// Pixel-in / window-out bundle for gray_window_buffer.
// frame_cnt exists only when GRAY_WIN_FRAME_CNT_EN is defined.
interface gray_window_buffer_if
    import gray_window_buffer_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
);
    localparam int ROW_W = clog2(IMG_HEIGHT);
    localparam int COL_W = clog2(IMG_WIDTH);

    logic [DATA_W-1:0]           gray;
    logic                        gray_valid;
    logic                        frame_start;
    logic [WIN_SLOTS*DATA_W-1:0] win;
    logic                        win_valid;
    logic [ROW_W-1:0]            row;
    logic [COL_W-1:0]            col;
    logic                        frame_done;
`ifdef GRAY_WIN_FRAME_CNT_EN
    logic [15:0]                 frame_cnt;

    modport master (output gray, gray_valid, frame_start,
                    input  win, win_valid, row, col, frame_done, frame_cnt);
    modport slave  (input  gray, gray_valid, frame_start,
                    output win, win_valid, row, col, frame_done, frame_cnt);
`else
    modport master (output gray, gray_valid, frame_start,
                    input  win, win_valid, row, col, frame_done);
    modport slave  (input  gray, gray_valid, frame_start,
                    output win, win_valid, row, col, frame_done);
`endif

endinterface

// File: rtl/gray_window_buffer_lb.sv
// One line of pixel storage: combinational read, synchronous write.
// Deliberately unreset; stale contents are masked by the row gating upstream.
module gray_line_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem [DEPTH];

    assign rdata_o = mem[addr_i];

    always_ff @(posedge clk_i) begin
        if (we_i) mem[addr_i] <= wdata_i;
    end

endmodule

// File: rtl/gray_window_buffer.sv
// Sliding 3x3 gray window builder for the Sobel stage; emits interior windows only.
// Optional frame counter output enabled by GRAY_WIN_FRAME_CNT_EN.
module gray_window_buffer
    import gray_window_buffer_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
    input logic                  clk_i,
    input logic                  rst_i,
    gray_window_buffer_if.slave  bus
);
    localparam int ROW_W = clog2(IMG_HEIGHT);
    localparam int COL_W = clog2(IMG_WIDTH);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);

    logic                  valid_d;
    logic                  acc;
    logic [ROW_W-1:0]      row_q, row_eff;
    logic [COL_W-1:0]      col_q, col_eff;
    logic                  row_last, col_last, interior;
    logic [DATA_W-1:0]     lb0_rd, lb1_rd;
    logic [DATA_W-1:0]     win_q [WIN_SLOTS];
    logic                  win_valid_q, frame_done_q;
    logic [WIN_SLOTS*DATA_W-1:0] win_flat;

    // Rising edge of the converter's level valid; valid_d resets high so a
    // level already asserted out of reset is not taken as a pixel.
    assign acc = bus.gray_valid & ~valid_d;

    // A coincident frame_start makes the accepted pixel land at (0,0).
    assign row_eff  = bus.frame_start ? '0 : row_q;
    assign col_eff  = bus.frame_start ? '0 : col_q;
    assign row_last = (row_eff == ROW_LAST);
    assign col_last = (col_eff == COL_LAST);
    assign interior = (row_eff >= ROW_W'(2)) && (col_eff >= COL_W'(2));

    gray_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_WIDTH), .ADDR_W(COL_W)) u_lb0 (
        .clk_i   (clk_i),
        .we_i    (acc),
        .addr_i  (col_eff),
        .wdata_i (bus.gray),
        .rdata_o (lb0_rd)
    );

    gray_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_WIDTH), .ADDR_W(COL_W)) u_lb1 (
        .clk_i   (clk_i),
        .we_i    (acc),
        .addr_i  (col_eff),
        .wdata_i (lb0_rd),
        .rdata_o (lb1_rd)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_d      <= 1'b1;
            row_q        <= '0;
            col_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            for (int k = 0; k < WIN_SLOTS; k++) win_q[k] <= '0;
        end else begin
            valid_d      <= bus.gray_valid;
            win_valid_q  <= acc && interior;
            frame_done_q <= acc && row_last && col_last;
            if (acc) begin
                if (col_last) begin
                    col_q <= '0;
                    row_q <= row_last ? '0 : row_eff + ROW_W'(1);
                end else begin
                    col_q <= col_eff + COL_W'(1);
                    row_q <= row_eff;
                end
                for (int r = 0; r < 3; r++) begin
                    win_q[3*r]     <= win_q[3*r + 1];
                    win_q[3*r + 1] <= win_q[3*r + 2];
                end
                win_q[WIN_TR] <= lb1_rd;
                win_q[WIN_MR] <= lb0_rd;
                win_q[WIN_BR] <= bus.gray;
            end else if (bus.frame_start) begin
                row_q <= '0;
                col_q <= '0;
            end
        end
    end

    always_comb begin
        win_flat = '0;
        for (int k = 0; k < WIN_SLOTS; k++) win_flat[k*DATA_W +: DATA_W] = win_q[k];
    end

    assign bus.win        = win_flat;
    assign bus.win_valid  = win_valid_q;
    assign bus.row        = row_q;
    assign bus.col        = col_q;
    assign bus.frame_done = frame_done_q;

`ifdef GRAY_WIN_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    // Steps on the same condition that raises frame_done, so both appear together.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)                         frame_cnt_q <= '0;
        else if (acc && row_last && col_last) frame_cnt_q <= frame_cnt_q + 16'd1;
    end

    assign bus.frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_gray_window_buffer.sv
// Directed bench for gray_window_buffer at W=4, H=4, DATA_W=8.
// Frame counter checks compile in when GRAY_WIN_FRAME_CNT_EN is defined.
module tb_gray_window_buffer;

    logic clk_i;
    logic rst_i;
    int   checks;
    int   errors;
    int   wv_cnt;
    int   fd_cnt;

    gray_window_buffer_if #(.DATA_W(8), .IMG_WIDTH(4), .IMG_HEIGHT(4)) bus ();

    gray_window_buffer #(.DATA_W(8), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (rst_i && bus.win_valid)  wv_cnt++;
        if (rst_i && bus.frame_done) fd_cnt++;
    end

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pixel values are base + raster index, so window slot (i,j) is predictable.
    function automatic logic [71:0] exp_win(input int base, input int idx);
        logic [71:0] w;
        int r, c;
        r = idx / 4;
        c = idx % 4;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[(3*i + j)*8 +: 8] = 8'((base + (r - 2 + i)*4 + (c - 2 + j)) & 255);
        return w;
    endfunction

    task automatic pix(input int base, input int idx, input logic fs);
        int  nx;
        logic wv;
        nx = (idx + 1) % 16;
        wv = (idx / 4 >= 2) && (idx % 4 >= 2);
        @(negedge clk_i);
        bus.gray        = 8'((base + idx) & 255);
        bus.gray_valid  = 1'b1;
        bus.frame_start = fs;
        @(negedge clk_i);
        bus.gray_valid  = 1'b0;
        bus.frame_start = 1'b0;
        chk($sformatf("win_valid[%0d]", idx), 72'(bus.win_valid), 72'(wv));
        if (wv) chk($sformatf("win[%0d]", idx), bus.win, exp_win(base, idx));
        chk($sformatf("frame_done[%0d]", idx), 72'(bus.frame_done), 72'(idx == 15));
        chk($sformatf("row[%0d]", idx), 72'(bus.row), 72'(nx / 4));
        chk($sformatf("col[%0d]", idx), 72'(bus.col), 72'(nx % 4));
    endtask

    task automatic settle_counts();
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    task automatic full_frame(input int base, input string tag);
        int wv0, fd0;
        wv0 = wv_cnt;
        fd0 = fd_cnt;
        for (int i = 0; i < 16; i++) pix(base, i, 1'b0);
        settle_counts();
        chk({tag, "_windows"}, 72'(wv_cnt - wv0), 72'(4));
        chk({tag, "_frame_done"}, 72'(fd_cnt - fd0), 72'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_win"}, bus.win, 72'(0));
        chk({tag, "_win_valid"}, 72'(bus.win_valid), 72'(0));
        chk({tag, "_row"}, 72'(bus.row), 72'(0));
        chk({tag, "_col"}, 72'(bus.col), 72'(0));
        chk({tag, "_frame_done"}, 72'(bus.frame_done), 72'(0));
    endtask

    initial begin
        int wv0;
        checks = 0;
        errors = 0;
        wv_cnt = 0;
        fd_cnt = 0;
        rst_i  = 1'b0;
        bus.gray        = '0;
        bus.gray_valid  = 1'b0;
        bus.frame_start = 1'b0;

        // Reset values
        repeat (3) @(negedge clk_i);
        check_reset_outputs("reset");
        rst_i = 1'b1;

        // Full frame 0..15: windows after pixels 10,11,14,15 only
        full_frame(0, "frame1");

        // Valid held high through reset is not a pixel; one toggle gives one pixel
        @(negedge clk_i);
        rst_i = 1'b0;
        bus.gray_valid = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        repeat (10) @(negedge clk_i);
        chk("held_valid_col", 72'(bus.col), 72'(0));
        chk("held_valid_row", 72'(bus.row), 72'(0));
        bus.gray_valid = 1'b0;
        @(negedge clk_i);
        bus.gray_valid = 1'b1;
        @(negedge clk_i);
        bus.gray_valid = 1'b0;
        @(negedge clk_i);
        chk("toggle_col", 72'(bus.col), 72'(1));
        chk("toggle_row", 72'(bus.row), 72'(0));

        // Reset after pixel 9 of a frame, then a clean frame with no stale window
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        for (int i = 0; i < 10; i++) pix(100, i, 1'b0);
        rst_i = 1'b0;
        #1;
        check_reset_outputs("midframe_reset");
        @(negedge clk_i);
        rst_i = 1'b1;
        full_frame(0, "post_reset");

        // frame_start alone clears position; frame_start with a pixel makes it (0,0)
        wv0 = wv_cnt;
        for (int i = 0; i < 6; i++) pix(50, i, 1'b0);
        @(negedge clk_i);
        bus.frame_start = 1'b1;
        @(negedge clk_i);
        bus.frame_start = 1'b0;
        chk("fs_alone_row", 72'(bus.row), 72'(0));
        chk("fs_alone_col", 72'(bus.col), 72'(0));
        chk("fs_alone_win_valid", 72'(bus.win_valid), 72'(0));
        for (int i = 0; i < 6; i++) pix(60, i, 1'b0);
        pix(200, 0, 1'b1);
        for (int i = 1; i < 16; i++) pix(200, i, 1'b0);
        settle_counts();
        chk("restart_windows", 72'(wv_cnt - wv0), 72'(4));

        // Third frame since the last reset
        full_frame(30, "frame3");
        chk("frame_done_total", 72'(fd_cnt), 72'(4));
`ifdef GRAY_WIN_FRAME_CNT_EN
        chk("frame_cnt", 72'(bus.frame_cnt), 72'(3));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
